// File: rtl/cpu_test_pkg.sv
// Shared types and constants for the CPU test controller.
package cpu_test_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_e;

  localparam int TOHOST_PASS      = 1;
  localparam int TOHOST_VALID_BIT = 0;

  function automatic logic is_terminal(input state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr has priority over en.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i && (q_q != {W{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/cpu_test_controller.sv
// Holds the core in reset, runs it under a watchdog, and latches the tohost verdict.
// All status outputs decode registered state, so they follow the deciding cycle by one clock.
module cpu_test_controller
  import cpu_test_pkg::*;
#(
  parameter int             XLEN         = 32,
  parameter int             CNT_W        = 32,
  parameter int             RESET_CYCLES = 4,
  parameter int             TIMEOUT_CYC  = 10000,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_1000,
  parameter bit             HALT_ON_DONE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mem_we_i,
  input  logic [XLEN-1:0]  mem_addr_i,
  input  logic [XLEN-1:0]  mem_wdata_i,
  input  logic             retire_i,
  output logic             core_rst_o,
  output logic             running_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [XLEN-2:0]  fail_code_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] instret_count_o
);

  localparam int HOLD_W = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [XLEN-2:0]   fail_code_q, fail_code_d;
  logic [CNT_W-1:0]  cycle_q, instret_q;
  logic              tohost_wr, tohost_pass, wdog_expired;
  logic              run_en, cnt_clr;

  assign tohost_wr    = mem_we_i && (mem_addr_i == TOHOST_ADDR) && mem_wdata_i[TOHOST_VALID_BIT];
  assign tohost_pass  = (mem_wdata_i == XLEN'(TOHOST_PASS));
  // Compare at 64 bits so a narrow saturating counter cannot alias the limit.
  assign wdog_expired = (64'(cycle_q) == 64'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_HOLD;
      hold_q      <= '0;
      fail_code_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      fail_code_q <= fail_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    fail_code_d = fail_code_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_q == HOLD_W'(RESET_CYCLES)) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RUN: begin
        // A tohost write beats a watchdog expiry in the same cycle.
        if (tohost_wr) begin
          if (tohost_pass) begin
            state_d = ST_PASS;
          end else begin
            state_d     = ST_FAIL;
            fail_code_d = mem_wdata_i[XLEN-1:1];
          end
        end else if (wdog_expired) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    core_rst_o  = 1'b1;
    running_o   = 1'b0;
    done_o      = is_terminal(state_q);
    pass_o      = (state_q == ST_PASS);
    timeout_o   = (state_q == ST_TIMEOUT);
    fail_code_o = fail_code_q;
    case (state_q)
      ST_HOLD: core_rst_o = 1'b1;
      ST_RUN: begin
        core_rst_o = 1'b0;
        running_o  = 1'b1;
      end
      default: core_rst_o = HALT_ON_DONE;
    endcase
  end

  assign run_en  = (state_q == ST_RUN);
  assign cnt_clr = (state_q == ST_HOLD);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (run_en),
    .q_o    (cycle_q)
  );

  sat_counter #(.W(CNT_W)) u_instret_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (run_en && retire_i),
    .q_o    (instret_q)
  );

  assign cycle_count_o   = cycle_q;
  assign instret_count_o = instret_q;

endmodule

// File: tb/tb_cpu_test_controller.sv
// Directed bench: one instance with a short watchdog, one with 4-bit counters and no hold.
module tb_cpu_test_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: RESET_CYCLES=4, TIMEOUT_CYC=50, 32-bit counters
  logic        a_rst_n = 1'b0, a_we = 1'b0, a_retire = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        a_core_rst, a_running, a_done, a_pass, a_timeout;
  logic [30:0] a_fail_code;
  logic [31:0] a_cyc, a_inst;

  cpu_test_controller #(
    .XLEN(32), .CNT_W(32), .RESET_CYCLES(4), .TIMEOUT_CYC(50),
    .TOHOST_ADDR(32'h0000_1000), .HALT_ON_DONE(1'b1)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(a_rst_n), .mem_we_i(a_we), .mem_addr_i(a_addr),
    .mem_wdata_i(a_wdata), .retire_i(a_retire), .core_rst_o(a_core_rst),
    .running_o(a_running), .done_o(a_done), .pass_o(a_pass),
    .fail_code_o(a_fail_code), .timeout_o(a_timeout),
    .cycle_count_o(a_cyc), .instret_count_o(a_inst)
  );

  // Instance B: RESET_CYCLES=0, CNT_W=4
  logic        b_rst_n = 1'b0, b_we = 1'b0, b_retire = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        b_core_rst, b_running, b_done, b_pass, b_timeout;
  logic [30:0] b_fail_code;
  logic [3:0]  b_cyc, b_inst;

  cpu_test_controller #(
    .XLEN(32), .CNT_W(4), .RESET_CYCLES(0), .TIMEOUT_CYC(10000),
    .TOHOST_ADDR(32'h0000_1000), .HALT_ON_DONE(1'b1)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(b_rst_n), .mem_we_i(b_we), .mem_addr_i(b_addr),
    .mem_wdata_i(b_wdata), .retire_i(b_retire), .core_rst_o(b_core_rst),
    .running_o(b_running), .done_o(b_done), .pass_o(b_pass),
    .fail_code_o(b_fail_code), .timeout_o(b_timeout),
    .cycle_count_o(b_cyc), .instret_count_o(b_inst)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_idle();
    a_we = 1'b0; a_addr = '0; a_wdata = '0; a_retire = 1'b0;
  endtask

  task automatic a_write(input logic [31:0] addr, input logic [31:0] data);
    a_we = 1'b1; a_addr = addr; a_wdata = data;
    tick(1);
    a_idle();
  endtask

  // Pulse reset off-edge, release, then wait out the 5-edge hold into RUN.
  task automatic a_restart();
    a_rst_n = 1'b0;
    #2;
    tick(1);
    a_rst_n = 1'b1;
    tick(5);
  endtask

  initial begin
    // Reset values
    #3;
    chk("rst_core_rst", a_core_rst, 1);
    chk("rst_running", a_running, 0);
    chk("rst_done", a_done, 0);
    chk("rst_cycle", a_cyc, 0);
    chk("rst_instret", a_inst, 0);

    // Hold sequencing: core_rst high through 4 edges, RUN on the 5th
    tick(1);
    a_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("hold_core_rst", a_core_rst, 1);
      chk("hold_running", a_running, 0);
    end
    tick(1);
    chk("run_entry_running", a_running, 1);
    chk("run_entry_core_rst", a_core_rst, 0);
    chk("run_entry_cycle", a_cyc, 0);

    // 20 cycles with 12 retires, then pass
    for (int i = 0; i < 20; i++) begin
      a_retire = (i < 12);
      tick(1);
    end
    a_retire = 1'b0;
    chk("pre_pass_cycle", a_cyc, 20);
    chk("pre_pass_instret", a_inst, 12);
    a_write(32'h0000_1000, 32'h1);
    chk("pass_pass", a_pass, 1);
    chk("pass_done", a_done, 1);
    chk("pass_fail_code", a_fail_code, 0);
    chk("pass_instret", a_inst, 12);
    chk("pass_cycle", a_cyc, 21);
    chk("pass_core_rst", a_core_rst, 1);
    chk("pass_running", a_running, 0);
    a_retire = 1'b1;
    a_write(32'h0000_1000, 32'h7);
    a_retire = 1'b0;
    tick(2);
    chk("pass_sticky", a_pass, 1);
    chk("pass_frozen_cycle", a_cyc, 21);
    chk("pass_frozen_instret", a_inst, 12);

    // Failure code, ignoring even-valued and wrong-address writes
    a_restart();
    chk("restart_running", a_running, 1);
    chk("restart_cycle", a_cyc, 0);
    a_write(32'h0000_1000, 32'h6);
    a_write(32'h0000_1004, 32'h1);
    chk("ignored_running", a_running, 1);
    chk("ignored_done", a_done, 0);
    a_write(32'h0000_1000, 32'h7);
    chk("fail_done", a_done, 1);
    chk("fail_code", a_fail_code, 3);
    chk("fail_pass", a_pass, 0);
    chk("fail_timeout", a_timeout, 0);
    chk("fail_cycle", a_cyc, 3);

    // Asynchronous reset in the middle of RUN
    a_restart();
    a_retire = 1'b1;
    tick(10);
    a_retire = 1'b0;
    chk("midrun_cycle", a_cyc, 10);
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("async_core_rst", a_core_rst, 1);
    chk("async_running", a_running, 0);
    chk("async_cycle", a_cyc, 0);
    chk("async_instret", a_inst, 0);
    tick(1);
    a_rst_n = 1'b1;
    tick(4);
    chk("rehold_core_rst", a_core_rst, 1);
    tick(1);
    chk("rehold_running", a_running, 1);
    chk("rehold_cycle", a_cyc, 0);

    // Watchdog expiry at cycle_count 49
    tick(49);
    chk("wdog_pre_cycle", a_cyc, 49);
    chk("wdog_pre_timeout", a_timeout, 0);
    chk("wdog_pre_running", a_running, 1);
    tick(1);
    chk("wdog_timeout", a_timeout, 1);
    chk("wdog_done", a_done, 1);
    chk("wdog_pass", a_pass, 0);
    chk("wdog_cycle", a_cyc, 50);
    a_write(32'h0000_1000, 32'h1);
    chk("wdog_late_pass", a_pass, 0);

    // Tohost pass on the expiry cycle wins
    a_restart();
    tick(49);
    chk("race_pre_cycle", a_cyc, 49);
    a_write(32'h0000_1000, 32'h1);
    chk("race_pass", a_pass, 1);
    chk("race_timeout", a_timeout, 0);

    // Instance B: zero hold cycles and 4-bit saturation
    chk("b_rst_core_rst", b_core_rst, 1);
    b_rst_n = 1'b1;
    tick(1);
    chk("b_running", b_running, 1);
    chk("b_core_rst", b_core_rst, 0);
    b_retire = 1'b1;
    tick(40);
    b_retire = 1'b0;
    chk("b_sat_cycle", b_cyc, 15);
    chk("b_sat_instret", b_inst, 15);
    chk("b_no_timeout", b_timeout, 0);
    chk("b_still_running", b_running, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
